// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_stage                                                           |
// | MEM pipeline stage: EX->MEM latch, variable-latency load wait, load extend.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_stage #(
    parameter int PC_W     = 32,
    parameter int STALL_W  = 6,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic [PC_W+46:0]     ex_to_mem_bus,
    input  logic                 data_sram_rvalid,
    input  logic [31:0]          data_sram_rdata,
    output logic                 stallreq_for_mem,
    output logic                 mem_timeout,
    output logic [PC_W+37:0]     mem_to_wb_bus,
    output logic [37:0]          mem_to_rf_bus
);

    localparam int BUS_W     = PC_W + 47;
    localparam int CNT_W     = $clog2(MAX_WAIT + 1);
    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    localparam logic [2:0] LOAD_LB  = 3'b001;
    localparam logic [2:0] LOAD_LBU = 3'b010;
    localparam logic [2:0] LOAD_LH  = 3'b011;
    localparam logic [2:0] LOAD_LHU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [BUS_W-1:0] latch_q, latch_d;
    state_t           state_q, state_d;
    logic [31:0]      cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PC_W-1:0]  w_pc;
    logic [2:0]       w_load_op;
    logic             w_ram_en;
    logic [3:0]       w_ram_wen;
    logic             w_sel_rf_res;
    logic             w_rf_we;
    logic [4:0]       w_rf_waddr;
    logic [31:0]      w_ex_result;

    logic             w_kill;
    logic             w_take;
    logic             w_upd;
    logic             w_is_load;
    logic [31:0]      w_ld_data;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ld_ext;
    logic [31:0]      w_rf_wdata;
    logic             w_rf_we_out;
    logic             w_unused_stall;

    assign {w_pc, w_load_op, w_ram_en, w_ram_wen, w_sel_rf_res,
            w_rf_we, w_rf_waddr, w_ex_result} = latch_q;

    // Only the MEM and WB stall bits matter here; the rest belong to other stages.
    assign w_unused_stall = ^stall;

    assign w_kill = flush | (stall[STALL_MEM] & ~stall[STALL_WB]);
    assign w_take = ~flush & ~stall[STALL_MEM];
    assign w_upd  = w_kill | w_take;

    assign w_is_load = w_ram_en & (w_ram_wen == 4'd0);

    always_comb begin
        latch_d = latch_q;
        if (w_kill) begin
            latch_d = '0;
        end else if (w_take) begin
            latch_d = ex_to_mem_bus;
        end
    end

    // Any latch update restarts the FSM so the next instruction is judged fresh.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        if (w_upd) begin
            state_d = S_IDLE;
            cap_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_is_load) begin
                        if (data_sram_rvalid) begin
                            state_d = S_DONE;
                            cap_d   = data_sram_rdata;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (data_sram_rvalid) begin
                        state_d = S_DONE;
                        cap_d   = data_sram_rdata;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= '0;
            state_q <= S_IDLE;
            cap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            latch_q <= latch_d;
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_ld_data = (state_q == S_DONE) ? cap_q : data_sram_rdata;

    always_comb begin
        w_byte = w_ld_data[7:0];
        case (w_ex_result[1:0])
            2'd0:    w_byte = w_ld_data[7:0];
            2'd1:    w_byte = w_ld_data[15:8];
            2'd2:    w_byte = w_ld_data[23:16];
            default: w_byte = w_ld_data[31:24];
        endcase
    end

    assign w_half = w_ex_result[1] ? w_ld_data[31:16] : w_ld_data[15:0];

    always_comb begin
        w_ld_ext = w_ld_data;
        case (w_load_op)
            LOAD_LB:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: w_ld_ext = {24'd0, w_byte};
            LOAD_LH:  w_ld_ext = {{16{w_half[15]}}, w_half};
            LOAD_LHU: w_ld_ext = {16'd0, w_half};
            default:  w_ld_ext = w_ld_data;
        endcase
    end

    assign stallreq_for_mem = w_is_load & (state_q != S_DONE) & ~data_sram_rvalid;
    assign mem_timeout      = (state_q == S_WAIT) & (cnt_q == CNT_MAX);

    // Suppress the write while waiting so the bypass never forwards stale load data.
    assign w_rf_we_out = w_rf_we & ~stallreq_for_mem;
    assign w_rf_wdata  = w_sel_rf_res ? w_ld_ext : w_ex_result;

    assign mem_to_wb_bus = {w_pc, w_rf_we_out, w_rf_waddr, w_rf_wdata};
    assign mem_to_rf_bus = {w_rf_we_out, w_rf_waddr, w_rf_wdata};

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_stage                                                        |
// | Directed self-checking bench for mem_access_stage.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_access_stage;

    localparam int PC_W = 32;

    logic              clk;
    logic              rst;
    logic [5:0]        stall;
    logic              flush;
    logic [PC_W+46:0]  ex_to_mem_bus;
    logic              data_sram_rvalid;
    logic [31:0]       data_sram_rdata;
    logic              stallreq_for_mem;
    logic              mem_timeout;
    logic [PC_W+37:0]  mem_to_wb_bus;
    logic [37:0]       mem_to_rf_bus;

    int n_checks;
    int n_errors;

    mem_access_stage #(
        .PC_W     (PC_W),
        .STALL_W  (6),
        .MAX_WAIT (15)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .data_sram_rvalid (data_sram_rvalid),
        .data_sram_rdata  (data_sram_rdata),
        .stallreq_for_mem (stallreq_for_mem),
        .mem_timeout      (mem_timeout),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_rf_bus    (mem_to_rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                       input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {pc, op, en, wen, sel, we, wa, res};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction, latch it on the next edge, then return the bus to a bubble.
    task automatic issue(input logic [78:0] b);
        ex_to_mem_bus = b;
        stall = 6'b000000;
        step();
        ex_to_mem_bus = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wb"}, mem_to_wb_bus, 80'd0);
        check({tag, "_rf"}, mem_to_rf_bus, 80'd0);
        check({tag, "_stallreq"}, stallreq_for_mem, 80'd0);
        check({tag, "_timeout"}, mem_timeout, 80'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        stall = 6'b000000;
        flush = 1'b0;
        ex_to_mem_bus = '0;
        data_sram_rvalid = 1'b0;
        data_sram_rdata = 32'd0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");

        // ALU result forwarded in the same cycle
        issue(mk(32'h100, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234_5678));
        #1;
        check("alu_rf", mem_to_rf_bus, {1'b1, 5'd5, 32'h1234_5678});
        check("alu_wb", mem_to_wb_bus, {32'h100, 1'b1, 5'd5, 32'h1234_5678});
        check("alu_stallreq", stallreq_for_mem, 1'b0);

        // Store never stalls
        issue(mk(32'h200, 3'b000, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0040));
        #1;
        check("store_stallreq", stallreq_for_mem, 1'b0);

        // Zero-wait lb at byte 3
        issue(mk(32'h104, 3'b001, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h1000_0003));
        data_sram_rvalid = 1'b1;
        data_sram_rdata = 32'h80FF_0000;
        #1;
        check("lb_rf", mem_to_rf_bus, {1'b1, 5'd7, 32'hFFFF_FF80});
        check("lb_stallreq", stallreq_for_mem, 1'b0);
        data_sram_rvalid = 1'b0;

        // Zero-wait lh upper half, sign-extended
        issue(mk(32'h120, 3'b011, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1000_0002));
        data_sram_rvalid = 1'b1;
        data_sram_rdata = 32'h8001_1234;
        #1;
        check("lh_rf", mem_to_rf_bus, {1'b1, 5'd3, 32'hFFFF_8001});
        data_sram_rvalid = 1'b0;

        // Zero-wait lbu at byte 1
        issue(mk(32'h124, 3'b010, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h1000_0001));
        data_sram_rvalid = 1'b1;
        data_sram_rdata = 32'h0000_F000;
        #1;
        check("lbu_rf", mem_to_rf_bus, {1'b1, 5'd4, 32'h0000_00F0});
        data_sram_rvalid = 1'b0;

        // lhu with three wait cycles
        issue(mk(32'h108, 3'b100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h2000_0002));
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("lhu_wait%0d_stallreq", i), stallreq_for_mem, 1'b1);
            check($sformatf("lhu_wait%0d_we", i), mem_to_rf_bus[37], 1'b0);
            step();
        end
        data_sram_rvalid = 1'b1;
        data_sram_rdata = 32'hBEEF_0001;
        #1;
        check("lhu_done_stallreq", stallreq_for_mem, 1'b0);
        check("lhu_done_rf", mem_to_rf_bus, {1'b1, 5'd9, 32'h0000_BEEF});
        stall = 6'b000000;
        step();
        data_sram_rvalid = 1'b0;

        // lw whose data arrives while the pipeline is held externally
        issue(mk(32'h10C, 3'b000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h3000_0000));
        stall = 6'b011111;
        #1;
        check("cap_first_stallreq", stallreq_for_mem, 1'b1);
        step();
        data_sram_rvalid = 1'b1;
        data_sram_rdata = 32'hCAFE_BABE;
        #1;
        check("cap_rvalid_stallreq", stallreq_for_mem, 1'b0);
        step();
        data_sram_rvalid = 1'b0;
        data_sram_rdata = 32'hDEAD_DEAD;
        #1;
        check("cap_hold1_stallreq", stallreq_for_mem, 1'b0);
        check("cap_hold1_rf", mem_to_rf_bus, {1'b1, 5'd10, 32'hCAFE_BABE});
        step();
        check("cap_hold2_rf", mem_to_rf_bus, {1'b1, 5'd10, 32'hCAFE_BABE});
        stall = 6'b000000;
        #1;
        check("cap_release_wb", mem_to_wb_bus, {32'h10C, 1'b1, 5'd10, 32'hCAFE_BABE});
        step();

        // Timeout after 16 WAIT cycles, then flush
        issue(mk(32'h110, 3'b000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h0000_0040));
        stall = 6'b011111;
        #1;
        check("to_idle_timeout", mem_timeout, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            step();
            check($sformatf("to_wait%0d_timeout", k), mem_timeout, (k >= 16) ? 1'b1 : 1'b0);
            check($sformatf("to_wait%0d_stallreq", k), stallreq_for_mem, 1'b1);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check_idle_outputs("to_flush");
        stall = 6'b000000;

        // Reset in the middle of a wait; later rvalid must not leak out
        issue(mk(32'h114, 3'b011, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h0000_0002));
        stall = 6'b011111;
        step();
        step();
        check("rstmid_wait_stallreq", stallreq_for_mem, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall = 6'b000000;
        #1;
        check_idle_outputs("rstmid");
        data_sram_rvalid = 1'b1;
        data_sram_rdata = 32'h1234_5678;
        #1;
        check_idle_outputs("rstmid_rvalid");
        step();
        data_sram_rvalid = 1'b0;
        #1;
        check_idle_outputs("rstmid_after");

        // Flush and rvalid together: flush wins
        issue(mk(32'h118, 3'b001, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h0000_0001));
        stall = 6'b011111;
        #1;
        check("fl_rv_stallreq", stallreq_for_mem, 1'b1);
        step();
        flush = 1'b1;
        data_sram_rvalid = 1'b1;
        data_sram_rdata = 32'h0000_AA00;
        step();
        flush = 1'b0;
        data_sram_rvalid = 1'b0;
        #1;
        check_idle_outputs("fl_rv");
        stall = 6'b000000;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage for the 5-stage core, sitting between EX and WB. It latches the EX→MEM bus under the shared stall/flush protocol. It supports variable-latency data-SRAM reads with a valid handshake, requesting a pipeline stall until read data arrives. It extracts and extends byte, halfword and word loads, and forwards final write-back data (load result included) to the register-file bypass network.

## Interface
- PC_W, 32, width of the carried PC.
- STALL_W, 6, width of the stall vector; this stage's input-latch bit is 3 and the WB bit is 4.
- MAX_WAIT, 15, wait-cycle count at which `mem_timeout` asserts; minimum 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  pipeline stall vector; 1 = Stop.
- flush  in  1  synchronous flush of the input latch.
- ex_to_mem_bus  in  PC_W+47  {pc, load_op[2:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}.
- data_sram_rvalid  in  1  read data valid this cycle.
- data_sram_rdata  in  32  read data, meaningful only when rvalid=1.
- stallreq_for_mem  out  1  stall request to the stall controller.
- mem_timeout  out  1  wait has lasted MAX_WAIT cycles.
- mem_to_wb_bus  out  PC_W+38  {pc, rf_we, rf_waddr, rf_wdata}.
- mem_to_rf_bus  out  38  {rf_we, rf_waddr, rf_wdata} bypass.

## Operation
- **Input latch priority:**
  1. rst → 0.
  2. flush → 0.
  3. stall[3]=1 and stall[4]=0 → 0 (bubble).
  4. stall[3]=0 → load ex_to_mem_bus.
  5. Otherwise hold.
- **Load detection:** is_load = data_ram_en & (data_ram_wen==0). Stores and ALU ops never stall.
- **load_op encoding:** 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu. Other codes behave as lw.
- **Byte/half selection:**
  - Byte/half select comes from ex_result[1:0]; halfword selection uses ex_result[1] only.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Misaligned lh/lw are not checked; the misalignment bits are ignored.
- **FSM (loads only):**
  - IDLE: a load is latched and rvalid=0 → WAIT. If rvalid=1 in the same cycle, capture rdata → DONE.
  - WAIT: rvalid=1 → capture rdata → DONE.
  - DONE: hold the captured data until the latch next loads, flushes, or bubbles, then → IDLE.
  - Any latch load, flush, or bubble forces next state IDLE and clears the capture register. That latch update then re-evaluates against the new instruction.
- **Data source:** load data is the captured register in DONE, otherwise live rdata.
- **Stall request:** stallreq_for_mem = is_load & (state≠DONE) & ~rvalid (combinational).
- **Wait counter:**
  - Clears on entry to WAIT.
  - Increments each WAIT cycle, saturating at MAX_WAIT.
  - mem_timeout = (state==WAIT) & (cnt==MAX_WAIT).
- **Write data:** rf_wdata = sel_rf_res ? extended load data : ex_result.
- **Write enable:** rf_we on both output buses = latched rf_we & ~stallreq_for_mem. While stalled, WB and bypass never see a stale load value marked valid.

## Timing
- Reset: latch, FSM (IDLE), capture register and counter all 0. All outputs are 0 the cycle after rst.
- **Zero-wait load:** when rvalid=1 in the first cycle the load is latched, there is no stall and data passes combinationally.
- **N-cycle wait:** rvalid arriving N cycles after latching gives exactly N stall-request cycles.
- **Outputs:** mem_to_wb_bus and mem_to_rf_bus are combinational from latch plus FSM, so the bypass is valid in the same cycle.
- **WB stall during a wait:**
  - rvalid arriving while stall[3]=1 for an external reason is captured.
  - DONE then keeps stallreq_for_mem=0 even though rvalid has dropped.
- **Flush or reset mid-wait:**
  - FSM returns to IDLE.
  - A late rvalid for the killed load is ignored unless a new load is latched in that same cycle. The SRAM interface guarantees no stale responses.
- **Simultaneous flush and rvalid:** flush wins; the data is not captured.

## Test plan
- **Word ALU op:** latch sel_rf_res=0, rf_we=1, waddr=5, ex_result=0x1234_5678 → same cycle: wb/rf buses carry we=1, waddr 5, data 0x12345678; stallreq=0.
- **Zero-wait load:** lb, addr[1:0]=3, rvalid=1, rdata=0x80FF_0000 → wdata=0xFFFF_FF80, no stall.
- **3-cycle wait:** lhu, addr[1:0]=2, rvalid after 3 cycles, rdata=0xBEEF_0001 → stallreq high for exactly 3 cycles with rf_we=0, then wdata=0x0000_BEEF.
- **Capture under external stall:** rvalid pulses while stall[3]=stall[4]=1 with rdata=0xCAFEBABE, then stall drops 2 cycles later → stallreq stays 0; lw result 0xCAFEBABE is held and delivered.
- **Timeout:** MAX_WAIT=15, rvalid never arrives → mem_timeout rises on the 16th WAIT cycle and stays high. Flush → state IDLE, outputs 0.
- **Reset mid-wait:** rst during WAIT → next cycle all outputs 0. Subsequent rvalid=1 with an empty latch → no effect.
